// File: rtl/rv32_decode_pkg.sv
// Shared constants, field positions and the decoded-bundle type for the RV32I decode stage.
// Optional feature macro used by this slice: RV32_DECODE_WB_BYPASS_EN (see rv32_regfile).
package rv32_decode_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned REG_AW  = 5;

  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SRL  = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  localparam int unsigned OPC_LSB = 0;
  localparam int unsigned RD_LSB  = 7;
  localparam int unsigned F3_LSB  = 12;
  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS2_LSB = 20;
  localparam int unsigned IMM_LSB = 20;
  localparam int unsigned F7_LSB  = 25;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  rd;
    logic        illegal;
  } dec_fields_t;

  // Only the OP/OP-IMM ALU subset is supported; everything else is flagged illegal.
  function automatic logic is_illegal(input logic [INSTR_W-1:0] instr);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ill;
    opc = instr[OPC_LSB +: 7];
    f3  = instr[F3_LSB +: 3];
    f7  = instr[F7_LSB +: 7];
    ill = 1'b0;
    case (opc)
      OP_REG: ill = !((f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SRL))));
      OP_IMM: begin
        if (f3 == F3_SLL)      ill = (f7 != F7_BASE);
        else if (f3 == F3_SRL) ill = !((f7 == F7_BASE) || (f7 == F7_ALT));
        else                   ill = 1'b0;
      end
      default: ill = 1'b1;
    endcase
    return ill;
  endfunction

endpackage

// File: rtl/rv32_regfile.sv
// Integer register file: two combinational read ports, one synchronous write port, x0 reads zero.
// RV32_DECODE_WB_BYPASS_EN makes a same-cycle write visible on the read ports (write-through).
module rv32_regfile
  import rv32_decode_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  output logic [WIDTH-1:0]  rs1_data_c,
  output logic [WIDTH-1:0]  rs2_data_c,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i
);

  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic             wr_live;

  assign wr_live = we_i && (waddr_i != REG_AW'(0));

  // Synchronous reset clears every entry; x0 is never written afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else if (wr_live) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rs1_data_c = regs_q[rs1_addr_i];
    rs2_data_c = regs_q[rs2_addr_i];
`ifdef RV32_DECODE_WB_BYPASS_EN
    if (wr_live && (waddr_i == rs1_addr_i)) rs1_data_c = wdata_i;
    if (wr_live && (waddr_i == rs2_addr_i)) rs2_data_c = wdata_i;
`endif
    if (rs1_addr_i == REG_AW'(0)) rs1_data_c = '0;
    if (rs2_addr_i == REG_AW'(0)) rs2_data_c = '0;
  end

endmodule

// File: rtl/rv32_decode_stage.sv
// RV32I decode stage: splits the fetch word into ALU fields, reads operands, one-entry output register.
// Write-through regfile behaviour is selected by RV32_DECODE_WB_BYPASS_EN.
module rv32_decode_stage
  import rv32_decode_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_valid,
  output logic               if_ready,
  input  logic [INSTR_W-1:0] if_instr,
  output logic               ex_valid,
  input  logic               ex_ready,
  output logic [6:0]         ex_opcode,
  output logic [2:0]         ex_funct3,
  output logic [6:0]         ex_funct7,
  output logic [11:0]        ex_imm,
  output logic [4:0]         ex_shamt,
  output logic [4:0]         ex_rd_addr,
  output logic [WIDTH-1:0]   ex_rs1_data,
  output logic [WIDTH-1:0]   ex_rs2_data,
  output logic               ex_illegal,
  input  logic               wb_en,
  input  logic [4:0]         wb_addr,
  input  logic [WIDTH-1:0]   wb_data
);

  logic              ex_valid_q, ex_valid_d;
  dec_fields_t       fields_q, fields_d, fields_dec;
  logic [WIDTH-1:0]  rs1_q, rs1_d, rs2_q, rs2_d;
  logic [WIDTH-1:0]  rs1_rd, rs2_rd;
  logic              accept;

  rv32_regfile #(
    .WIDTH    (WIDTH),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .rs1_addr_i (if_instr[RS1_LSB +: REG_AW]),
    .rs2_addr_i (if_instr[RS2_LSB +: REG_AW]),
    .rs1_data_c (rs1_rd),
    .rs2_data_c (rs2_rd),
    .we_i       (wb_en),
    .waddr_i    (wb_addr),
    .wdata_i    (wb_data)
  );

  assign if_ready = !ex_valid_q || ex_ready;
  assign accept   = if_valid && if_ready;

  // Fields are taken raw regardless of format; only the opcode is squashed on illegal words.
  always_comb begin
    fields_dec.illegal = is_illegal(if_instr);
    fields_dec.opcode  = fields_dec.illegal ? 7'h00 : if_instr[OPC_LSB +: 7];
    fields_dec.funct3  = if_instr[F3_LSB +: 3];
    fields_dec.funct7  = if_instr[F7_LSB +: 7];
    fields_dec.imm     = if_instr[IMM_LSB +: 12];
    fields_dec.shamt   = if_instr[RS2_LSB +: 5];
    fields_dec.rd      = if_instr[RD_LSB +: 5];
  end

  always_comb begin
    ex_valid_d = ex_valid_q;
    fields_d   = fields_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    if (accept) begin
      ex_valid_d = 1'b1;
      fields_d   = fields_dec;
      rs1_d      = rs1_rd;
      rs2_d      = rs2_rd;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      fields_q   <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      fields_q   <= fields_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_opcode   = fields_q.opcode;
  assign ex_funct3   = fields_q.funct3;
  assign ex_funct7   = fields_q.funct7;
  assign ex_imm      = fields_q.imm;
  assign ex_shamt    = fields_q.shamt;
  assign ex_rd_addr  = fields_q.rd;
  assign ex_illegal  = fields_q.illegal;
  assign ex_rs1_data = rs1_q;
  assign ex_rs2_data = rs2_q;

endmodule

// File: doc/rv32_decode_stage.md
Name: rv32_decode_stage

Overview:
- Decode stage that feeds the integer ALU in the RV32I pipeline.
- Accepts raw 32-bit instruction words from fetch through a valid/ready handshake.
- Reads the integer register file and splits the word into the fields the ALU consumes (opcode, funct3, funct7, imm, shamt, operands).
- Presents those fields from a one-entry pipeline register with a valid/ready handshake toward execute; owns the register file write port from writeback.

Parameters:
WIDTH, 32, register/data width in bits
NUM_REGS, 32, architectural registers; x0 hardwired to zero

Ports:
clk  input  1  clock
rst  input  1  reset
if_valid  input  1  fetch offers instruction
if_ready  output  1  stage can accept
if_instr  input  32  instruction word
ex_valid  output  1  decoded bundle valid
ex_ready  input  1  execute accepts bundle
ex_opcode  output  7  opcode; forced 7'h00 when illegal
ex_funct3  output  3  instr[14:12]
ex_funct7  output  7  instr[31:25]
ex_imm  output  12  instr[31:20]
ex_shamt  output  5  instr[24:20]
ex_rd_addr  output  5  instr[11:7]
ex_rs1_data  output  WIDTH  register value of instr[19:15]
ex_rs2_data  output  WIDTH  register value of instr[24:20]
ex_illegal  output  1  instruction not supported
wb_en  input  1  writeback enable
wb_addr  input  5  writeback register index
wb_data  input  WIDTH  writeback data

Behaviour:
- Reset:
  - rst is synchronous, active-high.
  - On reset, all outputs except if_ready go to 0; if_ready is 1 in the first cycle after reset.
  - All register file entries clear to 0.
  - An in-flight bundle is dropped, with no partial output.
- Handshake:
  - if_ready = !ex_valid || ex_ready (combinational).
  - Accept occurs when if_valid && if_ready; the bundle is registered at that edge and ex_valid=1 next cycle. Latency is 1 cycle.
  - When ex_valid && ex_ready && !if_valid, ex_valid clears.
  - While ex_valid && !ex_ready, all ex_* outputs hold stable.
  - Full throughput: one instruction per cycle when ex_ready is held high.
- Register file:
  - 2 combinational read ports addressed from if_instr; 1 synchronous write port.
  - Writes with wb_addr==0 are ignored, and reads of x0 return 0.
  - Operand data is captured at accept. A later writeback does not update a held bundle; hazard ordering is the issuer's responsibility.
- Legality (ex_illegal=1 and ex_opcode=0, so execute produces 0):
  - opcode not 7'b0110011 or 7'b0010011.
  - R-type: funct7 not 7'h00/7'h20, or funct7=7'h20 with funct3 other than 0 or 5.
  - I-type: funct3=1 with instr[31:25]!=0.
  - I-type: funct3=5 with instr[31:25] not 7'h00/7'h20.
- Illegal instructions are still accepted and passed downstream; they never stall.
- Fields are always taken raw from the word: imm/shamt also on R-type, funct7 also on I-type.
- Simultaneous accept and writeback to a source register: behaviour is set by WB_BYPASS_EN.

Optional Feature:
- Macro: RV32_DECODE_WB_BYPASS_EN.
- Defined: a read whose address equals wb_addr while wb_en=1 and wb_addr!=0 returns wb_data in the same cycle (write-through).
- Undefined: such a read returns the pre-write value; the new value is visible from the next cycle.

Decomposition:
- Package rv32_decode_pkg holds:
  - opcode constants OP_REG=7'b0110011 and OP_IMM=7'b0010011.
  - funct3 constants ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND = 0..7.
  - funct7 constants F7_BASE=7'h00 and F7_ALT=7'h20.
  - field bit-position localparams.
- Sub-module rv32_regfile: 2R1W register file with x0 hardwiring and bypass under the macro.
- Decode, legality check and the pipeline register stay in rv32_decode_stage.

Test Plan:
- Preload x1=5, x2=7; issue 0x002081B3 (add x3,x1,x2) with ex_ready=1 → next cycle ex_valid=1, opcode=7'h33, funct3=0, funct7=0, rd=3, rs1_data=5, rs2_data=7, ex_illegal=0.
- 0x402081B3 (sub) → funct7=7'h20, illegal=0. 0xFFF00293 (addi x5,x0,-1) → opcode=7'h13, imm=12'hFFF, rs1_data=0.
- 0x4032D313 (srai x6,x5,3) → shamt=3, funct7=7'h20, illegal=0. 0x40209093 (slli with funct7=0x20) → ex_illegal=1, ex_opcode=0.
- Backpressure: hold ex_ready=0 for 3 cycles with if_valid=1 → if_ready=0, ex_* outputs unchanged; release → back-to-back bundles in order, none lost or duplicated.
- Same-cycle wb_en=1, wb_addr=1, wb_data=0xDEADBEEF while accepting a read of x1 (old value 5) → rs1_data=0xDEADBEEF with the macro, 5 without it. A write to x0 leaves x0 reading 0.
- Assert rst while ex_valid=1 and ex_ready=0 → next cycle ex_valid=0, if_ready=1, and a read of x1 returns 0.
